// File: rtl/crc_engine.sv
// Streaming CRC generator/checker: folds a framed byte stream DATA_WIDTH bits per cycle
// into a parametrised CRC and returns the result, residue flag and byte count on a handshake port.
module crc_engine #(
   parameter int          CRC_WIDTH   = 32,
   parameter int          DATA_WIDTH  = 32,
   parameter logic [31:0] POLYNOMIAL  = 32'h04C11DB7,
   parameter logic [31:0] SEED        = 32'hFFFFFFFF,
   parameter bit          REFLECT_IN  = 1'b1,
   parameter bit          REFLECT_OUT = 1'b1,
   parameter logic [31:0] XOR_OUT     = 32'hFFFFFFFF,
   parameter logic [31:0] RESIDUE     = 32'hC704DD7B,
   localparam int         NUM_LANES   = DATA_WIDTH / 8,
   localparam int         BYTES_W     = $clog2(NUM_LANES) + 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_sop,
   input  logic                  in_eop,
   input  logic [BYTES_W-1:0]    in_bytes,
   output logic                  crc_valid,
   input  logic                  crc_ready,
   output logic [CRC_WIDTH-1:0]  crc_out,
   output logic                  crc_ok,
   output logic [15:0]           frame_bytes,
   output logic                  sop_err
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESULT
   } state_t;

   localparam logic [CRC_WIDTH-1:0] POLY_C    = POLYNOMIAL[CRC_WIDTH-1:0];
   localparam logic [CRC_WIDTH-1:0] SEED_C    = SEED[CRC_WIDTH-1:0];
   localparam logic [CRC_WIDTH-1:0] XOR_C     = XOR_OUT[CRC_WIDTH-1:0];
   localparam logic [CRC_WIDTH-1:0] RESIDUE_C = RESIDUE[CRC_WIDTH-1:0];
   localparam logic [BYTES_W-1:0]   FULL_C    = BYTES_W'(NUM_LANES);

   state_t                 state;
   logic [CRC_WIDTH-1:0]   crc_reg;
   logic [15:0]            byte_cnt;

   logic                   accept;
   logic [BYTES_W-1:0]     lanes_used;
   logic [CRC_WIDTH-1:0]   crc_next;
   logic [16:0]            cnt_sum;
   logic [15:0]            cnt_next;

   // One byte, shifted MSB-first through the register (after optional input reflection).
   function automatic logic [CRC_WIDTH-1:0] fold_byte(input logic [CRC_WIDTH-1:0] crc,
                                                     input logic [7:0] data);
      logic [CRC_WIDTH-1:0] r;
      logic [7:0]           d;
      logic                 fb;
      r = crc;
      for (int i = 0; i < 8; i++) begin
         d[i] = REFLECT_IN ? data[7-i] : data[i];
      end
      for (int i = 7; i >= 0; i--) begin
         fb = r[CRC_WIDTH-1] ^ d[i];
         r  = {r[CRC_WIDTH-2:0], 1'b0};
         if (fb) begin
            r = r ^ POLY_C;
         end
      end
      return r;
   endfunction

   function automatic logic [CRC_WIDTH-1:0] finalize(input logic [CRC_WIDTH-1:0] crc);
      logic [CRC_WIDTH-1:0] r;
      for (int i = 0; i < CRC_WIDTH; i++) begin
         r[i] = REFLECT_OUT ? crc[CRC_WIDTH-1-i] : crc[i];
      end
      return r ^ XOR_C;
   endfunction

   assign accept = in_valid & in_ready;

   // A short eop word only contributes its first in_bytes lanes; 0 or oversize means full.
   always_comb begin
      lanes_used = FULL_C;
      if (in_eop && (in_bytes != '0) && (in_bytes < FULL_C)) begin
         lanes_used = in_bytes;
      end
   end

   always_comb begin
      crc_next = in_sop ? SEED_C : crc_reg;
      for (int lane = 0; lane < NUM_LANES; lane++) begin
         if (lane < int'(lanes_used)) begin
            crc_next = fold_byte(crc_next, in_data[8*lane +: 8]);
         end
      end
   end

   always_comb begin
      cnt_sum  = {1'b0, (in_sop ? 16'd0 : byte_cnt)} + 17'(lanes_used);
      cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         crc_reg     <= SEED_C;
         byte_cnt    <= 16'd0;
         in_ready    <= 1'b1;
         crc_valid   <= 1'b0;
         crc_out     <= '0;
         crc_ok      <= 1'b0;
         frame_bytes <= 16'd0;
         sop_err     <= 1'b0;
      end else begin
         sop_err <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && in_sop) begin
                  crc_reg  <= crc_next;
                  byte_cnt <= cnt_next;
                  if (in_eop) begin
                     state       <= RESULT;
                     in_ready    <= 1'b0;
                     crc_valid   <= 1'b1;
                     crc_out     <= finalize(crc_next);
                     crc_ok      <= (crc_next == RESIDUE_C);
                     frame_bytes <= cnt_next;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (accept) begin
                  crc_reg  <= crc_next;
                  byte_cnt <= cnt_next;
                  sop_err  <= in_sop;
                  if (in_eop) begin
                     state       <= RESULT;
                     in_ready    <= 1'b0;
                     crc_valid   <= 1'b1;
                     crc_out     <= finalize(crc_next);
                     crc_ok      <= (crc_next == RESIDUE_C);
                     frame_bytes <= cnt_next;
                  end
               end
            end
            RESULT: begin
               // Input stays held off for the transfer cycle itself.
               if (crc_ready) begin
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  crc_valid <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
